block_ram_pair_reader: RTL and testbench

Controller that drives a one-write/two-read block RAM (1-cycle registered read, read data held while read enable is low) from the owning side. It fills the RAM from a valid/ready word stream, then replays the contents as a stream of word pairs, using both read ports every cycle for double bandwidth. It sits between the weight/parameter loader and a compute stage that consumes two operands per cycle and reuses them `NUM_REPEAT` times.

---
 rtl/block_ram_pair_reader.sv | 158 +++++++++++++++
 tb/tb_block_ram_pair_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_pair_reader.sv
// block_ram_pair_reader: fills a 1W/2R block RAM from a valid/ready word
// stream, then replays it NUM_REPEAT times as even/odd word pairs using both
// read ports each cycle, and pulses done once the last pair is consumed.
module block_ram_pair_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int NUM_REPEAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [DATA_WIDTH-1:0]    o_data_a,
  output logic [DATA_WIDTH-1:0]    o_data_b,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic [$clog2(DEPTH)-1:0] ram_wr_addr,
  output logic                     ram_rw,
  output logic [$clog2(DEPTH)-1:0] ram_rd_addr_a,
  output logic [$clog2(DEPTH)-1:0] ram_rd_addr_b,
  output logic                     ram_rd_en_a,
  output logic                     ram_rd_en_b,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data_a,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data_b
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PAIRS = DEPTH / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int RW    = (NUM_REPEAT > 1) ? $clog2(NUM_REPEAT) : 1;

  localparam logic [AW-1:0] WC_LAST = AW'(DEPTH - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(PAIRS - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(NUM_REPEAT - 1);

  typedef enum logic [1:0] {
    LOAD,
    READ,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] wc, wc_next;
  logic [PW-1:0] p, p_next;
  logic [RW-1:0] r, r_next;
  logic          pending, pending_next;
  logic          valid_next;
  logic          issue;
  logic [AW-1:0] rd_base;

  // Read data goes straight from the RAM to the consumer; the RAM's own
  // output register provides the one-cycle latency and holds during stalls.
  assign o_data_a    = ram_rd_data_a;
  assign o_data_b    = ram_rd_data_b;
  assign ram_wr_data = wr_data;
  assign rd_base     = AW'({p, 1'b0});

  // State and counter registers; reset abandons any partial load or stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      wc      <= '0;
      p       <= '0;
      r       <= '0;
      pending <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      wc      <= wc_next;
      p       <= p_next;
      r       <= r_next;
      pending <= pending_next;
      o_valid <= valid_next;
    end
  end

  // Next-state, counter updates and RAM/handshake strobes for each phase.
  always_comb begin
    state_next    = state;
    wc_next       = wc;
    p_next        = p;
    r_next        = r;
    pending_next  = pending;
    valid_next    = o_valid;
    issue         = 1'b0;
    wr_ready      = 1'b0;
    ram_rw        = 1'b0;
    ram_wr_addr   = '0;
    ram_rd_en_a   = 1'b0;
    ram_rd_en_b   = 1'b0;
    ram_rd_addr_a = '0;
    ram_rd_addr_b = '0;
    done          = 1'b0;

    case (state)
      LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_rw      = 1'b1;
          ram_wr_addr = wc;
          if (wc == WC_LAST) begin
            wc_next    = '0;
            state_next = READ;
          end else begin
            wc_next = wc + 1'b1;
          end
        end
      end

      READ: begin
        // A new pair may be fetched when the output slot is empty or is
        // being drained this cycle, so streaming has no bubbles.
        issue = pending & (~o_valid | o_ready);
        if (issue) begin
          ram_rd_en_a   = 1'b1;
          ram_rd_en_b   = 1'b1;
          ram_rd_addr_a = rd_base;
          ram_rd_addr_b = rd_base | AW'(1);
          valid_next    = 1'b1;
          if (p == P_LAST) begin
            p_next = '0;
            if (r == R_LAST) begin
              r_next       = '0;
              pending_next = 1'b0;
            end else begin
              r_next = r + 1'b1;
            end
          end else begin
            p_next = p + 1'b1;
          end
        end else if (o_valid & o_ready) begin
          valid_next = 1'b0;
          if (!pending) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        done         = 1'b1;
        state_next   = LOAD;
        wc_next      = '0;
        p_next       = '0;
        r_next       = '0;
        pending_next = 1'b1;
        valid_next   = 1'b0;
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_block_ram_pair_reader.sv
// tb_block_ram_pair_reader: checks the pair reader against behavioural RAM
// models and a queue of expected pairs built from the loaded words.
module tb_block_ram_pair_reader;

  localparam int DW  = 16;
  localparam int D8  = 8;
  localparam int NR8 = 2;
  localparam int P8  = (D8 / 2) * NR8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Signals for the DEPTH=8, NUM_REPEAT=2 instance
  logic [DW-1:0] wr_data, o_data_a, o_data_b, ram_wr_data, ram_rd_data_a, ram_rd_data_b;
  logic          wr_valid, wr_ready, o_valid, o_ready, done, ram_rw, ram_rd_en_a, ram_rd_en_b;
  logic [2:0]    ram_wr_addr, ram_rd_addr_a, ram_rd_addr_b;
  logic [DW-1:0] mem8 [D8];

  // Signals for the DEPTH=2, NUM_REPEAT=1 instance
  logic [DW-1:0] wr_data2, o_data_a2, o_data_b2, ram_wr_data2, ram_rd_data_a2, ram_rd_data_b2;
  logic          wr_valid2, wr_ready2, o_valid2, o_ready2, done2, ram_rw2, ram_rd_en_a2, ram_rd_en_b2;
  logic [0:0]    ram_wr_addr2, ram_rd_addr_a2, ram_rd_addr_b2;
  logic [DW-1:0] mem2 [2];

  typedef struct {
    int          validMode;
    int          readyMode;
    logic [15:0] base;
    bit          randomData;
    int          resetAfter;
  } vec_t;

  vec_t vecs[8];

  block_ram_pair_reader #(.DATA_WIDTH(DW), .DEPTH(D8), .NUM_REPEAT(NR8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_valid(o_valid), .o_ready(o_ready),
    .done(done),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_rw(ram_rw),
    .ram_rd_addr_a(ram_rd_addr_a), .ram_rd_addr_b(ram_rd_addr_b),
    .ram_rd_en_a(ram_rd_en_a), .ram_rd_en_b(ram_rd_en_b),
    .ram_rd_data_a(ram_rd_data_a), .ram_rd_data_b(ram_rd_data_b)
  );

  block_ram_pair_reader #(.DATA_WIDTH(DW), .DEPTH(2), .NUM_REPEAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data2), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
    .o_data_a(o_data_a2), .o_data_b(o_data_b2), .o_valid(o_valid2), .o_ready(o_ready2),
    .done(done2),
    .ram_wr_data(ram_wr_data2), .ram_wr_addr(ram_wr_addr2), .ram_rw(ram_rw2),
    .ram_rd_addr_a(ram_rd_addr_a2), .ram_rd_addr_b(ram_rd_addr_b2),
    .ram_rd_en_a(ram_rd_en_a2), .ram_rd_en_b(ram_rd_en_b2),
    .ram_rd_data_a(ram_rd_data_a2), .ram_rd_data_b(ram_rd_data_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural block RAMs: write on port A, registered reads that hold
  // their value while the read enable is low.
  always @(posedge clk) begin
    if (ram_rw) mem8[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en_a) ram_rd_data_a <= mem8[ram_rd_addr_a];
    if (ram_rd_en_b) ram_rd_data_b <= mem8[ram_rd_addr_b];
    if (ram_rw2) mem2[ram_wr_addr2] <= ram_wr_data2;
    if (ram_rd_en_a2) ram_rd_data_a2 <= mem2[ram_rd_addr_a2];
    if (ram_rd_en_b2) ram_rd_data_b2 <= mem2[ram_rd_addr_b2];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=completion", name);
  endtask

  // Load eight words, then stream and score every pair of the 8-deep instance.
  task automatic applyStimulus(input vec_t v);
    logic [DW-1:0] words [D8];
    logic [DW-1:0] expA[$];
    logic [DW-1:0] expB[$];
    logic [DW-1:0] heldA, heldB;
    int loaded, guard, c, beats, lastBeat, stallLeft;
    bit stallUsed, doneSeen, prevStall, aborted;

    for (int i = 0; i < D8; i++)
      words[i] = v.randomData ? DW'($urandom) : v.base + DW'(i);
    for (int rr = 0; rr < NR8; rr++)
      for (int pp = 0; pp < D8 / 2; pp++) begin
        expA.push_back(words[2 * pp]);
        expB.push_back(words[2 * pp + 1]);
      end

    loaded = 0;
    guard  = 0;
    while (loaded < D8 && guard < 100) begin
      @(negedge clk);
      o_ready = 1'b0;
      case (v.validMode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (guard % 2 == 0);
        default: wr_valid = ($urandom_range(0, 1) == 1);
      endcase
      wr_data = words[loaded];
      #1;
      checkOutput("load_wr_ready", 32'(wr_ready), 1);
      checkOutput("load_rd_en", 32'(ram_rd_en_a | ram_rd_en_b), 0);
      checkOutput("load_rw", 32'(ram_rw), 32'(wr_valid));
      if (wr_valid) begin
        checkOutput("load_wr_addr", 32'(ram_wr_addr), loaded);
        loaded++;
      end
      guard++;
    end
    if (loaded < D8) reportTimeout("load_timeout");

    c = 0; beats = 0; lastBeat = -1; stallLeft = 0;
    stallUsed = 0; doneSeen = 0; prevStall = 0; aborted = 0;
    heldA = '0; heldB = '0;
    while (!doneSeen && c < 200) begin
      @(negedge clk);
      wr_valid = 1'b0;
      case (v.readyMode)
        0: o_ready = 1'b1;
        1: begin
          if (o_valid && beats == 2 && !stallUsed) begin
            stallLeft = 3;
            stallUsed = 1;
          end
          o_ready = (stallLeft == 0);
          if (stallLeft > 0) stallLeft--;
        end
        default: o_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      checkOutput("read_wr_ready", 32'(wr_ready), 0);
      checkOutput("rw_and_rd_en", 32'(ram_rw & ram_rd_en_a), 0);
      if (c == 0) checkOutput("first_read_valid", 32'(o_valid), 0);
      if (prevStall) begin
        checkOutput("stall_hold_a", 32'(o_data_a), 32'(heldA));
        checkOutput("stall_hold_b", 32'(o_data_b), 32'(heldB));
      end
      if (o_valid && !o_ready) begin
        checkOutput("stall_rd_en", 32'(ram_rd_en_a | ram_rd_en_b), 0);
        heldA = o_data_a;
        heldB = o_data_b;
        prevStall = 1;
      end else begin
        prevStall = 0;
      end
      if (o_valid && o_ready) begin
        if (expA.size() == 0) begin
          reportTimeout("extra_beat");
        end else begin
          checkOutput("beat_a", 32'(o_data_a), 32'(expA.pop_front()));
          checkOutput("beat_b", 32'(o_data_b), 32'(expB.pop_front()));
        end
        if (v.readyMode == 0) checkOutput("beat_cycle", c, beats + 1);
        beats++;
        lastBeat = c;
        if (v.resetAfter > 0 && beats == v.resetAfter) begin
          aborted = 1;
          break;
        end
      end
      if (done) begin
        doneSeen = 1;
        checkOutput("done_cycle", c, lastBeat + 1);
        if (v.readyMode == 0) checkOutput("done_abs_cycle", c, P8 + 1);
      end
      c++;
    end

    if (aborted) begin
      @(negedge clk);
      o_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_o_valid", 32'(o_valid), 0);
      checkOutput("rst_wr_ready", 32'(wr_ready), 1);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_rd_en", 32'(ram_rd_en_a | ram_rd_en_b), 0);
      checkOutput("rst_rd_addr", 32'({ram_rd_addr_a, ram_rd_addr_b}), 0);
      checkOutput("rst_wr_addr", 32'(ram_wr_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    if (!doneSeen) reportTimeout("done_timeout");
    checkOutput("beat_count", beats, P8);
    @(negedge clk);
    o_ready = 1'b0;
    #1;
    checkOutput("done_one_cycle", 32'(done), 0);
    checkOutput("back_to_load", 32'(wr_ready), 1);
  endtask

  // Two back-to-back load/stream rounds on the 2-deep instance.
  task automatic checkDepthTwo();
    logic [DW-1:0] a, b;
    for (int k = 0; k < 2; k++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      @(negedge clk);
      wr_valid2 = 1'b1;
      wr_data2  = a;
      #1;
      checkOutput("d2_wr_ready", 32'(wr_ready2), 1);
      checkOutput("d2_wr_addr0", 32'(ram_wr_addr2), 0);
      @(negedge clk);
      wr_data2 = b;
      #1;
      checkOutput("d2_wr_addr1", 32'(ram_wr_addr2), 1);
      @(negedge clk);
      wr_valid2 = 1'b0;
      o_ready2  = 1'b1;
      #1;
      checkOutput("d2_t0_valid", 32'(o_valid2), 0);
      checkOutput("d2_t0_rd_en", 32'(ram_rd_en_a2 & ram_rd_en_b2), 1);
      @(negedge clk);
      #1;
      checkOutput("d2_valid", 32'(o_valid2), 1);
      checkOutput("d2_data_a", 32'(o_data_a2), 32'(a));
      checkOutput("d2_data_b", 32'(o_data_b2), 32'(b));
      @(negedge clk);
      #1;
      checkOutput("d2_done", 32'(done2), 1);
      checkOutput("d2_done_valid", 32'(o_valid2), 0);
      @(negedge clk);
      o_ready2 = 1'b0;
      #1;
      checkOutput("d2_done_pulse", 32'(done2), 0);
      checkOutput("d2_reload_ready", 32'(wr_ready2), 1);
    end
  endtask

  // Reset checks, the vector table, then the 2-deep corner case.
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_data = '0; o_ready = 1'b0;
    wr_valid2 = 1'b0; wr_data2 = '0; o_ready2 = 1'b0;

    vecs[0] = '{0, 0, 16'h0010, 1'b0, 0};
    vecs[1] = '{1, 0, 16'h0010, 1'b0, 0};
    vecs[2] = '{0, 1, 16'h0010, 1'b0, 0};
    vecs[3] = '{0, 0, 16'h0040, 1'b0, 3};
    vecs[4] = '{0, 0, 16'h0020, 1'b0, 0};
    vecs[5] = '{2, 2, 16'h0000, 1'b1, 0};
    vecs[6] = '{2, 2, 16'h0000, 1'b1, 0};
    vecs[7] = '{1, 2, 16'h0000, 1'b1, 0};

    #2;
    checkOutput("reset_wr_ready", 32'(wr_ready), 1);
    checkOutput("reset_o_valid", 32'(o_valid), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_rw", 32'(ram_rw), 0);
    checkOutput("reset_rd_en", 32'(ram_rd_en_a | ram_rd_en_b), 0);
    checkOutput("reset_d2_wr_ready", 32'(wr_ready2), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    checkDepthTwo();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
